// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receive-path sizes and the unpacker FSM state type
package uart_pkg;

  // Received block width from the UART receiver and the outgoing word width
  localparam int BLOCK_W   = 864;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = BLOCK_W / WORD_W;

  // Width of the word index presented to the downstream consumer
  localparam int IDX_W     = 5;

  // Unpacker FSM: IDLE waits for a block, DRAIN emits its words MSB-first
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } unpack_state_e;

endpackage : uart_pkg

// File: rtl/rx_word_unpacker.sv
// rtl/rx_word_unpacker.sv - splits a received UART block into a stream of MSB-first words
module rx_word_unpacker #(
  parameter int BLOCK_W = uart_pkg::BLOCK_W,
  parameter int WORD_W  = uart_pkg::WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BLOCK_W-1:0] rx_data,
  input  logic               data_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic [4:0]         word_idx,
  output logic               block_done,
  output logic               overrun,
  input  logic               clr_overrun
);

  import uart_pkg::*;

  // Words per block and the index of the final word
  localparam int         N_WORDS  = BLOCK_W / WORD_W;
  localparam logic [4:0] LAST_IDX = 5'(N_WORDS - 1);

  // The block register is shifted left one word per transfer, so the
  // current word always sits in its top WORD_W bits.
  logic [BLOCK_W-1:0] block_q;
  unpack_state_e      state_q;
  logic [4:0]         word_idx_q;
  logic               out_valid_q;
  logic               out_last_q;
  logic               block_done_q;
  logic               overrun_q;

  logic               xfer;
  logic               xfer_last;
  logic               overrun_set;
  logic [4:0]         word_idx_d;

  // Handshake decode: a transfer needs both valid and ready; the last-word
  // transfer is the only moment a new block may be accepted while draining.
  always_comb begin
    xfer        = out_valid_q & out_ready;
    xfer_last   = xfer & (word_idx_q == LAST_IDX);
    overrun_set = (state_q == ST_DRAIN) & data_ready & ~xfer_last;
    word_idx_d  = 5'(word_idx_q + 5'd1);
  end

  // Unpacker FSM with registered handshake, index and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      block_q      <= '0;
      word_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      block_done_q <= 1'b0;

      // Sticky drop flag: a new drop in the same cycle beats the clear
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (data_ready) begin
            block_q     <= rx_data;
            word_idx_q  <= '0;
            out_valid_q <= 1'b1;
            out_last_q  <= (LAST_IDX == 5'd0);
            state_q     <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (xfer_last) begin
            block_done_q <= 1'b1;
            if (data_ready) begin
              // Back-to-back block: reload with no bubble on out_valid
              block_q     <= rx_data;
              word_idx_q  <= '0;
              out_valid_q <= 1'b1;
              out_last_q  <= (LAST_IDX == 5'd0);
            end else begin
              block_q     <= '0;
              word_idx_q  <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              state_q     <= ST_IDLE;
            end
          end else if (xfer) begin
            block_q    <= block_q << WORD_W;
            word_idx_q <= word_idx_d;
            out_last_q <= (word_idx_d == LAST_IDX);
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output word comes straight from the top of the block register and is
  // forced to zero whenever no word is being offered.
  always_comb begin
    out_data = out_valid_q ? block_q[BLOCK_W-1 -: WORD_W] : '0;
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign word_idx   = word_idx_q;
  assign block_done = block_done_q;
  assign overrun    = overrun_q;

endmodule : rx_word_unpacker

// File: tb/tb_rx_word_unpacker.sv
// tb/tb_rx_word_unpacker.sv - directed self-checking bench for rx_word_unpacker
module tb_rx_word_unpacker;

  localparam int BW = 864;
  localparam int WW = 32;
  localparam int NW = 27;

  logic          clk;
  logic          rst;
  logic [BW-1:0] rx_data;
  logic          data_ready;
  logic [WW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [4:0]    word_idx;
  logic          block_done;
  logic          overrun;
  logic          clr_overrun;

  logic [BW-1:0] blk_a;
  logic [BW-1:0] blk_b;

  int n_tests;
  int n_fail;

  rx_word_unpacker #(.BLOCK_W(BW), .WORD_W(WW)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .data_ready  (data_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .word_idx    (word_idx),
    .block_done  (block_done),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WW-1:0] word_a(input int k);
    return 32'((k << 4) + k);
  endfunction

  function automatic logic [WW-1:0] word_b(input int k);
    return 32'hA5A5_0000 + 32'(k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit use_b);
    rx_data    = use_b ? blk_b : blk_a;
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("load_valid", 64'(out_valid), 64'd1);
    check("load_idx", 64'(word_idx), 64'd0);
  endtask

  task automatic drain_range(input bit use_b, input int from_k, input int to_k);
    out_ready = 1'b1;
    for (int k = from_k; k <= to_k; k++) begin
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_idx", 64'(word_idx), 64'(k));
      check("drain_data", 64'(out_data), 64'(use_b ? word_b(k) : word_a(k)));
      check("drain_last", 64'(out_last), 64'(k == NW - 1));
      step();
    end
  endtask

  task automatic check_done();
    check("done_pulse", 64'(block_done), 64'd1);
    check("done_valid", 64'(out_valid), 64'd0);
    check("done_data", 64'(out_data), 64'd0);
    step();
    check("done_single", 64'(block_done), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int xfers;
    int cyc;
    bit rdy;

    n_tests = 0;
    n_fail  = 0;
    blk_a   = '0;
    blk_b   = '0;
    for (int i = 0; i < NW; i++) begin
      blk_a[BW-1-WW*i -: WW] = word_a(i);
      blk_b[BW-1-WW*i -: WW] = word_b(i);
    end

    rst         = 1'b1;
    rx_data     = '0;
    data_ready  = 1'b0;
    out_ready   = 1'b0;
    clr_overrun = 1'b0;
    step();
    step();
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_idx", 64'(word_idx), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_done", 64'(block_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    step();

    // Straight drain with out_ready held high
    out_ready = 1'b1;
    load(1'b0);
    drain_range(1'b0, 0, NW - 1);
    check_done();

    // Drain with out_ready toggling, starting stalled
    out_ready = 1'b0;
    load(1'b0);
    k     = 0;
    xfers = 0;
    cyc   = 0;
    while (k < NW && cyc < 200) begin
      rdy       = cyc[0];
      out_ready = rdy;
      check("tog_valid", 64'(out_valid), 64'd1);
      check("tog_idx", 64'(word_idx), 64'(k));
      check("tog_data", 64'(out_data), 64'(word_a(k)));
      step();
      if (rdy) begin
        k++;
        xfers++;
      end
      cyc++;
    end
    check("tog_xfers", 64'(xfers), 64'(NW));
    check_done();

    // Second block arrives mid-drain at word 10: dropped, overrun set
    load(1'b0);
    drain_range(1'b0, 0, 9);
    rx_data    = blk_b;
    data_ready = 1'b1;
    check("ovr_idx10", 64'(word_idx), 64'd10);
    check("ovr_data10", 64'(out_data), 64'(word_a(10)));
    step();
    data_ready = 1'b0;
    check("ovr_set", 64'(overrun), 64'd1);
    drain_range(1'b0, 11, NW - 1);
    check_done();
    for (int i = 0; i < 3; i++) begin
      check("ovr_no_b", 64'(out_valid), 64'd0);
      step();
    end
    check("ovr_sticky", 64'(overrun), 64'd1);

    // Clear racing a new drop: set wins; then clear alone
    load(1'b0);
    out_ready   = 1'b0;
    data_ready  = 1'b1;
    clr_overrun = 1'b1;
    step();
    data_ready = 1'b0;
    check("clr_race", 64'(overrun), 64'd1);
    check("clr_hold_idx", 64'(word_idx), 64'd0);
    step();
    clr_overrun = 1'b0;
    check("clr_alone", 64'(overrun), 64'd0);
    drain_range(1'b0, 0, NW - 1);
    check_done();

    // New block on the same cycle as the last-word transfer
    load(1'b0);
    drain_range(1'b0, 0, NW - 2);
    check("b2b_last", 64'(out_last), 64'd1);
    rx_data    = blk_b;
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    check("b2b_valid", 64'(out_valid), 64'd1);
    check("b2b_idx", 64'(word_idx), 64'd0);
    check("b2b_data", 64'(out_data), 64'(word_b(0)));
    check("b2b_done", 64'(block_done), 64'd1);
    check("b2b_overrun", 64'(overrun), 64'd0);
    check("b2b_lastclr", 64'(out_last), 64'd0);
    drain_range(1'b1, 0, NW - 1);
    check_done();

    // Reset in the middle of a drain, with data_ready asserted during reset
    load(1'b0);
    drain_range(1'b0, 0, 4);
    check("mid_idx5", 64'(word_idx), 64'd5);
    rst        = 1'b1;
    rx_data    = blk_b;
    data_ready = 1'b1;
    step();
    rst        = 1'b0;
    data_ready = 1'b0;
    check("mrst_valid", 64'(out_valid), 64'd0);
    check("mrst_data", 64'(out_data), 64'd0);
    check("mrst_idx", 64'(word_idx), 64'd0);
    check("mrst_last", 64'(out_last), 64'd0);
    check("mrst_done", 64'(block_done), 64'd0);
    step();
    check("mrst_done2", 64'(block_done), 64'd0);
    check("mrst_ignored", 64'(out_valid), 64'd0);
    load(1'b0);
    drain_range(1'b0, 0, NW - 1);
    check_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rx_word_unpacker
